nibble_serial_add_ctrl: RTL and testbench

//  - Sequencer that wraps the 4-bit ripple-carry adder (rca4) to perform WIDTH-bit addition one nibble per cycle.
//  - Latches two WIDTH-bit operands and drives one nibble of each, plus the running carry, into rca4 each cycle.
//  - Captures rca4's s/co, feeds co back as the next ci, and assembles the WIDTH-bit sum.
//  - Sits directly upstream and downstream of rca4: it is the adder's only driver and its only consumer.

---
 rtl/nibble_serial_add_ctrl_pkg.sv | 8 +
 rtl/nibble_serial_add_ctrl_shreg.sv | 21 ++
 rtl/rca4.sv | 16 +
 rtl/nibble_serial_add_ctrl.sv | 87 ++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// rca_pkg: shared constants, FSM state type and counter sizing for the nibble-serial adder.
package rca_pkg;
    localparam int NIB_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_width(input int width);
        return (width / NIB_W) > 1 ? $clog2(width / NIB_W) : 1;
    endfunction
endpackage

// File: rtl/nibble_serial_add_ctrl_shreg.sv
// nibble_shreg: parallel-load register that shifts right one nibble per enable.
module nibble_shreg
    import rca_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [3:0]       nib
);
    logic [WIDTH-1:0] q;
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (load) q <= din;
        else if (shift) q <= {{NIB_W{1'b0}}, q[WIDTH-1:NIB_W]};
    end
    assign nib = q[NIB_W-1:0];
endmodule

// File: rtl/rca4.sv
// rca4: 4-bit ripple-carry adder driven by nibble_serial_add_ctrl.
module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;
    assign c[0] = ci;
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign co = c[4];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit add, one nibble per cycle through an external rca4.
// Optional signed-overflow output ovf when NIBBLE_ADD_OVF_EN is defined.
module nibble_serial_add_ctrl
    import rca_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_ci,
    input  logic [3:0]       add_s,
    input  logic             add_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef NIBBLE_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int N  = WIDTH / NIB_W;
    localparam int CW = cnt_width(WIDTH);
    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic            carry_q, cout_q, accept, run, last;
    logic [WIDTH-1:0] sum_q;
    logic [3:0]      a_nib, b_nib;
    assign accept = (state == IDLE) && in_valid;
    assign run    = (state == RUN);
    assign last   = run && (cnt == CW'(N - 1));
    nibble_shreg #(.WIDTH(WIDTH)) u_a_sh (
        .clk(clk), .rst(rst), .load(accept), .shift(run), .din(op_a), .nib(a_nib)
    );
    nibble_shreg #(.WIDTH(WIDTH)) u_b_sh (
        .clk(clk), .rst(rst), .load(accept), .shift(run), .din(op_b), .nib(b_nib)
    );
    always_comb begin
        state_n   = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        add_a     = run ? a_nib : 4'd0;
        add_b     = run ? b_nib : 4'd0;
        add_ci    = run ? carry_q : 1'b0;
        if (accept) state_n = RUN;
        if (last) state_n = DONE;
        if (out_valid && out_ready) state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                carry_q <= cin;
                cnt     <= '0;
            end
            // Low nibble enters first, so shifting in from the top leaves it at bit 0 after N steps.
            if (run) begin
                sum_q   <= {add_s, sum_q[WIDTH-1:NIB_W]};
                carry_q <= add_co;
                cnt     <= cnt + CW'(1);
            end
            if (last) cout_q <= add_co;
        end
    end
`ifdef NIBBLE_ADD_OVF_EN
    logic ovf_q;
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else if (last) ovf_q <= (add_a[3] == add_b[3]) && (add_s[3] != add_a[3]);
    end
    assign ovf = ovf_q;
`endif
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: table-driven and scoreboard checks of nibble_serial_add_ctrl with rca4.
module tb_nibble_serial_add_ctrl;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, cin, add_ci, add_co, out_valid, out_ready, cout;
    logic [15:0] op_a, op_b, sum;
    logic [3:0]  add_a, add_b, add_s;
`ifdef NIBBLE_ADD_OVF_EN
    logic        ovf;
`endif
    always #5 clk = ~clk;
    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin(cin),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
`ifdef NIBBLE_ADD_OVF_EN
        .ovf(ovf),
`endif
        .cout(cout)
    );
    rca4 u_rca (.a(add_a), .b(add_b), .ci(add_ci), .s(add_s), .co(add_co));
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;
    vec_t        vecs[8];
    logic [17:0] sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                            input logic [17:0] exp, input bit push);
        check("in_ready_before_accept", in_ready, 1);
        op_a = a; op_b = b; cin = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a = ~a; op_b = ~b; cin = ~ci;
        if (push) sb.push_back(exp);
    endtask
    task automatic wait_done(output int lat, output logic [3:0] trace);
        lat = 0;
        trace = 4'd0;
        while (!out_valid && lat < 20) begin
            if (lat < 4) trace[lat] = add_ci;
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_rise", out_valid, 1);
    endtask
    task automatic pop_check(input string tag);
        logic [17:0] e;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_sum"}, sum, e[15:0]);
        check({tag, "_cout"}, cout, e[16]);
`ifdef NIBBLE_ADD_OVF_EN
        check({tag, "_ovf"}, ovf, e[17]);
`endif
    endtask
    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("retire_out_valid", out_valid, 0);
        check("retire_in_ready", in_ready, 1);
    endtask
    initial begin
        int          lat;
        logic [3:0]  trace;
        logic [15:0] held;
        bit          seen;
        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'hBEEF, 16'h1234, 1'b0, 16'hD123, 1'b0, 1'b0};
        vecs[7] = '{16'h0FF0, 16'h0010, 1'b1, 16'h1001, 1'b0, 1'b0};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_add_ci", add_ci, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].ci, {vecs[i].ov, vecs[i].co, vecs[i].s}, 1'b1);
            wait_done(lat, trace);
            check("latency", lat, 4);
            if (vecs[i].a == 16'hFFFF && vecs[i].b == 16'h0001) check("ci_trace", trace, 4'b1110);
            pop_check("vec");
            check("done_add_a", add_a, 0);
            check("done_add_b", add_b, 0);
            check("done_add_ci", add_ci, 0);
            retire();
        end
        start_op(16'h1234, 16'h1111, 1'b0, {1'b0, 1'b0, 16'h2345}, 1'b1);
        wait_done(lat, trace);
        held = sum;
        out_ready = 1'b0; in_valid = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_sum_stable", sum, held);
            check("bp_sum", sum, 16'h2345);
            check("bp_cout", cout, 0);
        end
        in_valid = 1'b0;
        pop_check("bp");
        retire();
        @(posedge clk); #1;
        check("bp_nothing_accepted", in_ready, 1);
        start_op(16'hFFFF, 16'h0001, 1'b0, '0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_add_a", add_a, 0);
        check("mid_rst_add_b", add_b, 0);
        check("mid_rst_add_ci", add_ci, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", cout, 0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_result", seen, 0);
        start_op(16'h0F0F, 16'h0101, 1'b1, {1'b0, 1'b0, 16'h1011}, 1'b1);
        wait_done(lat, trace);
        check("post_rst_latency", lat, 4);
        pop_check("post_rst");
        retire();
        rst = 1'b1; in_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        check("rst_vs_valid_in_ready", in_ready, 1);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen = 1'b1;
        end
        check("rst_vs_valid_no_accept", seen, 0);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
